// File: rtl/dds_phase_sequencer_if.sv
// dds_phase_sequencer_if: control, config handshake and phase outputs of the DDS phase sequencer
interface dds_phase_sequencer_if #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             start;
  logic             stop;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ACC_W-1:0] cfg_tuning;
  logic [CNT_W-1:0] cfg_cycles;
  logic [3:0]       phase_out;
  logic             phase_valid;
  logic             wrap;
  logic             busy;
  logic             done;
  modport slave (
    input  start, stop, cfg_valid, cfg_tuning, cfg_cycles,
    output cfg_ready, phase_out, phase_valid, wrap, busy, done
  );
  modport master (
    output start, stop, cfg_valid, cfg_tuning, cfg_cycles,
    input  cfg_ready, phase_out, phase_valid, wrap, busy, done
  );
endinterface

// File: rtl/dds_phase_sequencer.sv
// dds_phase_sequencer: phase accumulator with start/stop, burst runs and wrap-aligned retuning
module dds_phase_sequencer #(
  parameter int               ACC_W      = 16,
  parameter int               CNT_W      = 8,
  parameter logic [ACC_W-1:0] DEFAULT_TW = 16'h1000
) (
  input  logic                  clk,
  input  logic                  reset,
  dds_phase_sequencer_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;
  logic [1:0]       r_state;
  logic [ACC_W-1:0] r_acc, r_tw, r_pend_tw;
  logic [CNT_W-1:0] r_cycles, r_pend_cycles, r_wrap_cnt;
  logic             r_pend_valid, r_cfg_ready, r_busy, r_wrap, r_done;
  logic [3:0]       r_phase;
  logic [ACC_W:0]   w_sum;
  logic             w_carry, w_xfer, w_burst_end, w_stopping, w_end;
  assign w_sum       = {1'b0, r_acc} + {1'b0, r_tw};
  assign w_carry     = w_sum[ACC_W];
  assign w_xfer      = bus.cfg_valid & r_cfg_ready;
  assign w_burst_end = (|r_cycles) & (r_wrap_cnt + 1'b1 == r_cycles);
  assign w_stopping  = bus.stop | (r_state == S_STOP);
  // a zero tuning word never wraps, so a stop request must end the run directly
  assign w_end       = (r_state != S_IDLE) &
                       ((w_carry & (w_burst_end | w_stopping)) | (~|r_tw & w_stopping));
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_acc         <= '0;
      r_tw          <= DEFAULT_TW;
      r_cycles      <= '0;
      r_pend_tw     <= '0;
      r_pend_cycles <= '0;
      r_pend_valid  <= 1'b0;
      r_wrap_cnt    <= '0;
      r_cfg_ready   <= 1'b1;
      r_busy        <= 1'b0;
      r_wrap        <= 1'b0;
      r_done        <= 1'b0;
      r_phase       <= '0;
    end else begin
      r_wrap <= 1'b0;
      r_done <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_xfer) begin
          r_tw     <= bus.cfg_tuning;
          r_cycles <= bus.cfg_cycles;
        end
        if (bus.start) begin
          r_state    <= S_RUN;
          r_acc      <= '0;
          r_wrap_cnt <= '0;
          r_busy     <= 1'b1;
        end
      end else if (w_end) begin
        r_state      <= S_IDLE;
        r_acc        <= '0;
        r_phase      <= '0;
        r_wrap       <= w_carry;
        r_done       <= 1'b1;
        r_busy       <= 1'b0;
        r_pend_valid <= 1'b0;
        r_cfg_ready  <= 1'b1;
      end else begin
        r_acc   <= w_sum[ACC_W-1:0];
        r_phase <= w_sum[ACC_W-1 -: 4];
        r_wrap  <= w_carry;
        if (bus.stop) r_state <= S_STOP;
        // the wrapping update still uses the old word; the pending one applies from here on
        if (w_carry & r_pend_valid) begin
          r_tw         <= r_pend_tw;
          r_cycles     <= r_pend_cycles;
          r_wrap_cnt   <= '0;
          r_pend_valid <= 1'b0;
          r_cfg_ready  <= 1'b1;
        end else begin
          if (w_carry & (|r_cycles)) r_wrap_cnt <= r_wrap_cnt + 1'b1;
          if (w_xfer) begin
            r_pend_tw     <= bus.cfg_tuning;
            r_pend_cycles <= bus.cfg_cycles;
            r_pend_valid  <= 1'b1;
            r_cfg_ready   <= 1'b0;
          end
        end
      end
    end
  end
  assign bus.cfg_ready   = r_cfg_ready;
  assign bus.phase_out   = r_phase;
  assign bus.phase_valid = r_busy;
  assign bus.busy        = r_busy;
  assign bus.wrap        = r_wrap;
  assign bus.done        = r_done;
endmodule
